golden_nonce_uart_tx: RTL and testbench

Downstream consumer of the hash cores' golden-nonce outputs. It captures the one-cycle golden_nonce_match strobes from up to four cores and queues the nonces in a small FIFO. Each queued nonce is sent on an 8N1 UART line as 4 bytes, LSB first. It sits between the hashcore instances and the board's serial pin, in the hash_clk domain.

---
 rtl/golden_nonce_uart_tx.sv | 201 ++++++++++++++++++++
 tb/tb_golden_nonce_uart_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/golden_nonce_uart_tx.sv
// Captures golden-nonce strobes from the hash cores, queues them and sends each as 4 bytes
// (LSB first) on an 8N1 UART line. Define NONCE_DEDUP_EN to drop consecutive duplicate pushes.
module golden_nonce_uart_tx #(
    parameter int unsigned NUM_CORES       = 2,
    parameter int unsigned FIFO_DEPTH_LOG2 = 3,
    parameter int unsigned CLKS_PER_BIT    = 434
) (
    input  logic                       hash_clk,
    input  logic                       reset,
    input  logic [32*NUM_CORES-1:0]    golden_nonce,
    input  logic [NUM_CORES-1:0]       golden_nonce_match,
    output logic                       txd,
    output logic                       tx_busy,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_count,
    output logic                       overflow
);

    localparam int unsigned Depth = 2 ** FIFO_DEPTH_LOG2;
    localparam int unsigned PtrW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

    logic [31:0]               hold_q [NUM_CORES];
    logic [NUM_CORES-1:0]      valid_q;
    logic [NUM_CORES-1:0]      drain_vec;
    logic [PtrW-1:0]           rr_ptr_q;
    logic [PtrW-1:0]           grant_idx;
    logic [PtrW-1:0]           cand;
    logic                      grant_valid;
    logic                      overflow_q;
    logic                      fifo_full;
    logic                      drain;
    logic                      push;
    logic                      pop;
    logic                      dup;

    logic [31:0]               mem_q [Depth];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_DEPTH_LOG2:0]  count_q;

    tx_state_e                 state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [2:0]                bit_q, bit_d;
    logic [1:0]                byte_q, byte_d;
    logic [31:0]               word_q, word_d;
    logic                      bit_end;

    // Round-robin: first valid hold at or after the pointer wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            cand = PtrW'((32'(rr_ptr_q) + k) % NUM_CORES);
            if (!grant_valid && valid_q[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign fifo_full = count_q[FIFO_DEPTH_LOG2];
    assign drain     = grant_valid && !fifo_full;
    assign push      = drain && !dup;

    always_comb begin
        drain_vec = '0;
        if (drain) drain_vec[grant_idx] = 1'b1;
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            overflow_q <= 1'b0;
            rr_ptr_q   <= '0;
            for (int unsigned i = 0; i < NUM_CORES; i++) hold_q[i] <= '0;
        end else begin
            if (drain) begin
                rr_ptr_q <= (grant_idx == PtrW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
            end
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                if (golden_nonce_match[i]) begin
                    hold_q[i]  <= golden_nonce[32*i +: 32];
                    valid_q[i] <= 1'b1;
                    // A reload while the old value is being drained loses nothing.
                    if (valid_q[i] && !drain_vec[i]) overflow_q <= 1'b1;
                end else if (drain_vec[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
        end
    end

`ifdef NONCE_DEDUP_EN
    logic [31:0] last_q;
    logic        last_valid_q;

    assign dup = last_valid_q && (hold_q[grant_idx] == last_q);

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            last_q       <= '0;
            last_valid_q <= 1'b0;
        end else if (push) begin
            last_q       <= hold_q[grant_idx];
            last_valid_q <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge hash_clk) begin
        if (push) mem_q[wr_ptr_q] <= hold_q[grant_idx];
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    assign bit_end = (cnt_q == CntW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        word_d  = word_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    word_d  = mem_q[rd_ptr_q];
                    byte_d  = '0;
                    bit_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: if (bit_end) state_d = StData;
            StData: begin
                if (bit_end) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (byte_q != 2'd3) begin
                        byte_d  = byte_q + 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge hash_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        txd = 1'b1;
        unique case (state_q)
            StStart: txd = 1'b0;
            StData:  txd = word_q[{byte_q, bit_q}];
            default: txd = 1'b1;
        endcase
    end

    assign tx_busy    = (state_q != StIdle) || (count_q != '0);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Directed bench for golden_nonce_uart_tx: 2 cores, 4 clocks per bit, 8-entry FIFO.
module tb_golden_nonce_uart_tx;

    logic        hash_clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] golden_nonce = '0;
    logic [1:0]  golden_nonce_match = '0;
    logic        txd;
    logic        tx_busy;
    logic [3:0]  fifo_count;
    logic        overflow;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          framing_errs = 0;
    logic [31:0] rx_q[$];
    int          start_q[$];

`ifdef NONCE_DEDUP_EN
    localparam int ExpDedupFrames = 2;
`else
    localparam int ExpDedupFrames = 3;
`endif

    golden_nonce_uart_tx #(
        .NUM_CORES      (2),
        .FIFO_DEPTH_LOG2(3),
        .CLKS_PER_BIT   (4)
    ) dut (
        .hash_clk          (hash_clk),
        .reset             (reset),
        .golden_nonce      (golden_nonce),
        .golden_nonce_match(golden_nonce_match),
        .txd               (txd),
        .tx_busy           (tx_busy),
        .fifo_count        (fifo_count),
        .overflow          (overflow)
    );

    always #5 hash_clk = ~hash_clk;
    always @(posedge hash_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic int start_at(input int i);
        if (i < start_q.size()) return start_q[i];
        return -100000;
    endfunction

    // UART receiver: samples mid-bit (cycle 2 of 4), abandons a frame cut by reset.
    initial begin
        logic [31:0] w;
        bit          abort;
        forever begin
            @(negedge hash_clk);
            if (!reset && txd === 1'b0) begin
                start_q.push_back(cyc);
                abort = 1'b0;
                w     = '0;
                for (int s = 0; s < 40 && !abort; s++) begin
                    repeat ((s == 0) ? 2 : 4) @(negedge hash_clk);
                    if (reset) abort = 1'b1;
                    else if (s % 10 == 0) begin
                        if (txd !== 1'b0) framing_errs++;
                    end else if (s % 10 == 9) begin
                        if (txd !== 1'b1) framing_errs++;
                    end else begin
                        w[(s / 10) * 8 + (s % 10) - 1] = txd;
                    end
                end
                if (!abort) rx_q.push_back(w);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge hash_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge hash_clk);
        golden_nonce_match = '0;
        reset = 1'b1;
        repeat (5) @(negedge hash_clk);
        reset = 1'b0;
        rx_q.delete();
        start_q.delete();
        framing_errs = 0;
    endtask

    // Launches a one-cycle strobe right after a rising edge; k is that edge's index.
    task automatic strobe(input int core, input logic [31:0] val, output int k);
        @(posedge hash_clk);
        #1;
        golden_nonce[32*core +: 32] = val;
        golden_nonce_match = 2'b01 << core;
        k = cyc;
        @(posedge hash_clk);
        #1;
        golden_nonce_match = '0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (tx_busy && n < budget) begin
            @(negedge hash_clk);
            n++;
        end
        check_eq({tag, "_idle"}, 64'(tx_busy), 64'd0);
    endtask

    initial begin
        int k, k0, dummy;

        // Reset values, asserted asynchronously before any edge is seen.
        #2 reset = 1'b1;
        repeat (2) @(negedge hash_clk);
        check_eq("rst_txd", 64'(txd), 64'd1);
        check_eq("rst_busy", 64'(tx_busy), 64'd0);
        check_eq("rst_count", 64'(fifo_count), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge hash_clk);
        check_eq("rst_txd_after", 64'(txd), 64'd1);

        // Single strobe: start bit 3 edges after launch, 160-cycle frame.
        strobe(0, 32'h3fbd_9207, k);
        @(negedge hash_clk);
        @(negedge hash_clk);
        check_eq("t1_count", 64'(fifo_count), 64'd1);
        check_eq("t1_txd_idle", 64'(txd), 64'd1);
        @(negedge hash_clk);
        check_eq("t1_txd_start", 64'(txd), 64'd0);
        check_eq("t1_count_pop", 64'(fifo_count), 64'd0);
        wait_idle("t1", 400);
        check_eq("t1_busy_fall", 64'(cyc), 64'(k + 163));
        check_eq("t1_start_cyc", 64'(start_at(0)), 64'(k + 3));
        check_eq("t1_frames", 64'(rx_q.size()), 64'd1);
        check_eq("t1_word", 64'(rx_at(0)), 64'h3fbd_9207);
        check_eq("t1_framing", 64'(framing_errs), 64'd0);
        check_eq("t1_ovf", 64'(overflow), 64'd0);

        // Simultaneous strobes while a core-1 frame is in flight (pointer back at 0).
        do_reset();
        strobe(1, 32'h5a5a_c3c3, k0);
        wait_cycles(8);
        @(posedge hash_clk);
        #1;
        golden_nonce = {32'h2222_2222, 32'h1111_1111};
        golden_nonce_match = 2'b11;
        k = cyc;
        @(posedge hash_clk);
        #1;
        golden_nonce_match = '0;
        @(negedge hash_clk);
        @(negedge hash_clk);
        check_eq("t2_count1", 64'(fifo_count), 64'd1);
        @(negedge hash_clk);
        check_eq("t2_count2", 64'(fifo_count), 64'd2);
        wait_idle("t2", 800);
        check_eq("t2_frames", 64'(rx_q.size()), 64'd3);
        check_eq("t2_word0", 64'(rx_at(0)), 64'h5a5a_c3c3);
        check_eq("t2_word1", 64'(rx_at(1)), 64'h1111_1111);
        check_eq("t2_word2", 64'(rx_at(2)), 64'h2222_2222);
        check_eq("t2_start0", 64'(start_at(0)), 64'(k0 + 3));
        check_eq("t2_gap1", 64'(start_at(1) - start_at(0)), 64'd161);
        check_eq("t2_gap2", 64'(start_at(2) - start_at(1)), 64'd161);
        check_eq("t2_framing", 64'(framing_errs), 64'd0);

        // FIFO full: 8 queued, 9th waits in hold, a 10th on the same core overwrites it.
        do_reset();
        strobe(0, 32'h0bad_f00d, k0);
        for (int i = 0; i < 9; i++) strobe(i % 2, 32'hc0de_0000 | 32'(i), dummy);
        wait_cycles(10);
        check_eq("t3_full", 64'(fifo_count), 64'd8);
        check_eq("t3_ovf0", 64'(overflow), 64'd0);
        check_eq("t3_busy", 64'(tx_busy), 64'd1);
        strobe(0, 32'hc0de_0009, dummy);
        wait_cycles(3);
        check_eq("t3_ovf1", 64'(overflow), 64'd1);
        check_eq("t3_still_full", 64'(fifo_count), 64'd8);
        wait_idle("t3", 2500);
        check_eq("t3_frames", 64'(rx_q.size()), 64'd10);
        check_eq("t3_word0", 64'(rx_at(0)), 64'h0bad_f00d);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t3_word%0d", i + 1), 64'(rx_at(i + 1)),
                     64'(32'hc0de_0000 | 32'(i)));
        end
        check_eq("t3_word9", 64'(rx_at(9)), 64'hc0de_0009);
        check_eq("t3_ovf_sticky", 64'(overflow), 64'd1);
        check_eq("t3_framing", 64'(framing_errs), 64'd0);

        // Reload in the same cycle the hold is drained.
        do_reset();
        @(posedge hash_clk);
        #1;
        golden_nonce[31:0] = 32'haaaa_0001;
        golden_nonce_match = 2'b01;
        @(posedge hash_clk);
        #1;
        golden_nonce[31:0] = 32'hbbbb_0002;
        @(posedge hash_clk);
        #1;
        golden_nonce_match = '0;
        wait_cycles(3);
        check_eq("t4_ovf", 64'(overflow), 64'd0);
        wait_idle("t4", 600);
        check_eq("t4_frames", 64'(rx_q.size()), 64'd2);
        check_eq("t4_word0", 64'(rx_at(0)), 64'haaaa_0001);
        check_eq("t4_word1", 64'(rx_at(1)), 64'hbbbb_0002);
        check_eq("t4_ovf_end", 64'(overflow), 64'd0);

        // Reset during DATA of byte 2 (a zero bit), with another nonce queued.
        do_reset();
        strobe(0, 32'hff00_ffff, k);
        strobe(1, 32'h1234_5678, dummy);
        while (cyc < k + 100) begin
            @(posedge hash_clk);
            #1;
        end
        check_eq("t5_pre_txd", 64'(txd), 64'd0);
        check_eq("t5_pre_count", 64'(fifo_count), 64'd1);
        #3 reset = 1'b1;
        #1;
        check_eq("t5_txd", 64'(txd), 64'd1);
        check_eq("t5_count", 64'(fifo_count), 64'd0);
        check_eq("t5_busy", 64'(tx_busy), 64'd0);
        repeat (5) @(negedge hash_clk);
        reset = 1'b0;
        rx_q.delete();
        start_q.delete();
        framing_errs = 0;
        repeat (300) @(negedge hash_clk);
        check_eq("t5_no_start", 64'(start_q.size()), 64'd0);
        check_eq("t5_txd_after", 64'(txd), 64'd1);
        check_eq("t5_busy_after", 64'(tx_busy), 64'd0);

        // Consecutive duplicate nonce from different cores.
        do_reset();
        strobe(0, 32'hdead_beef, dummy);
        strobe(1, 32'hdead_beef, dummy);
        strobe(0, 32'h0000_0001, dummy);
        wait_cycles(4);
        wait_idle("t6", 800);
        check_eq("t6_frames", 64'(rx_q.size()), 64'(ExpDedupFrames));
        check_eq("t6_word0", 64'(rx_at(0)), 64'hdead_beef);
`ifndef NONCE_DEDUP_EN
        check_eq("t6_word1", 64'(rx_at(1)), 64'hdead_beef);
`endif
        check_eq("t6_last", 64'(rx_at(ExpDedupFrames - 1)), 64'h0000_0001);
        check_eq("t6_ovf", 64'(overflow), 64'd0);
        check_eq("t6_framing", 64'(framing_errs), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
